// File: rtl/axi_pattern_master_pkg.sv
// axi_self_test_pkg: types and constants shared by the pattern master and its LFSR.
package axi_self_test_pkg;

  // Master sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_REPORT,
    ST_RPT_GAP,
    ST_FINISH
  } master_state_e;

  localparam logic [31:0] LFSR_POLY       = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED    = 32'hA5A5_0001;
  localparam logic [7:0]  CFG_REPORT_ADDR = 8'h8C;

  // Slave status bit flagged by a config-area write outside the decoded range.
  localparam int unsigned CONFIG_WRITE_OUTRANGE = 3;

  // One Galois step: shift right, fold the polynomial in when bit0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/axi_pattern_master_if.sv
// axi_pattern_master_if: AW/W/AR/R channel bundle between pattern master and slave.
interface axi_pattern_master_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WVALID,
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WVALID,
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_pattern_lfsr.sv
// axi_pattern_lfsr: 32-bit Galois pattern source; load has priority over step.
module axi_pattern_lfsr
  import axi_self_test_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_seed,
  output logic [31:0] o_value
);
  logic [31:0] r_value;

  // Pattern register: reload from seed or advance one word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_value <= RESET_SEED;
    else if (i_load) r_value <= i_seed;
    else if (i_step) r_value <= lfsr_next(r_value);
  end

  assign o_value = r_value;
endmodule

// File: rtl/axi_pattern_master.sv
// axi_pattern_master: writes NUM_WORDS LFSR words, reads them back, reports errors.
// Optional feature macro: CFG_REPORT_EN (write {16'h0, err_count} to REPORT_ADDR after reads).
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_WR_REQ  | AW/W valid, waiting for both handshakes
// ST_WR_GAP  | slave recovery after a write
// ST_RD_REQ  | AR valid until ARREADY, RREADY until RVALID
// ST_RD_GAP  | slave recovery after a read
// ST_REPORT  | error-count write to the config area
// ST_RPT_GAP | slave recovery after the report write
// ST_FINISH  | done pulse, pass resolved
module axi_pattern_master
  import axi_self_test_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           NUM_WORDS      = 16,
  parameter logic [31:0]           SEED           = DEFAULT_SEED,
  parameter int unsigned           GAP_CYCLES     = 4,
  parameter int unsigned           TIMEOUT_CYCLES = 64,
  parameter logic [ADDR_WIDTH-1:0] REPORT_ADDR    = ADDR_WIDTH'(CFG_REPORT_ADDR)
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  timeout,
  axi_pattern_master_if.master  m_axi
);
  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  master_state_e         r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_fail_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic [TMO_W-1:0]      r_tmo;
  logic [GAP_W-1:0]      r_gap;
  logic [15:0]           r_err;
  logic                  r_aw_done, r_w_done, r_ar_done, r_timeout, r_pass;
  logic [31:0]           w_lfsr;
  logic                  w_lfsr_load, w_lfsr_step, w_is_wr, w_timeout_now;
  logic                  w_awvalid, w_wvalid, w_arvalid, w_rready;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_wr_complete, w_rd_complete;
  logic                  w_tmo_hit, w_gap_end, w_last, w_pass_now, w_mismatch;

  axi_pattern_lfsr #(.RESET_SEED(SEED)) u_lfsr (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_load  (w_lfsr_load),
    .i_step  (w_lfsr_step),
    .i_seed  (SEED),
    .o_value (w_lfsr)
  );

  assign w_is_wr       = (r_state == ST_WR_REQ) || (r_state == ST_REPORT);
  assign w_awvalid     = w_is_wr && !r_aw_done;
  assign w_wvalid      = w_is_wr && !r_w_done;
  assign w_arvalid     = (r_state == ST_RD_REQ) && !r_ar_done;
  assign w_rready      = (r_state == ST_RD_REQ);
  assign w_aw_hs       = w_awvalid && m_axi.M_AXI_AWREADY;
  assign w_w_hs        = w_wvalid && m_axi.M_AXI_WREADY;
  assign w_ar_hs       = w_arvalid && m_axi.M_AXI_ARREADY;
  assign w_wr_complete = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_rd_complete = w_rready && m_axi.M_AXI_RVALID;
  assign w_mismatch    = m_axi.M_AXI_RDATA != DATA_WIDTH'(w_lfsr);
  assign w_tmo_hit     = (r_tmo == '0);
  assign w_gap_end     = (r_gap == '0);
  assign w_last        = (r_cnt == LAST_IDX);
  assign w_pass_now    = (r_err == 16'd0) && !r_timeout;

  // Next-state and LFSR control; completion wins over a same-cycle timeout.
  always_comb begin
    w_next_state  = r_state;
    w_lfsr_load   = 1'b0;
    w_lfsr_step   = 1'b0;
    w_timeout_now = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_WR_REQ;
          w_lfsr_load  = 1'b1;
        end
      end
      ST_WR_REQ, ST_REPORT: begin
        if (w_wr_complete) begin
          w_next_state = (r_state == ST_WR_REQ) ? ST_WR_GAP : ST_RPT_GAP;
        end else if (w_tmo_hit) begin
          w_next_state  = ST_FINISH;
          w_timeout_now = 1'b1;
        end
      end
      ST_WR_GAP: begin
        if (w_gap_end) begin
          if (w_last) begin
            w_next_state = ST_RD_REQ;
            w_lfsr_load  = 1'b1;
          end else begin
            w_next_state = ST_WR_REQ;
            w_lfsr_step  = 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        if (w_rd_complete) begin
          w_next_state = ST_RD_GAP;
        end else if (w_tmo_hit) begin
          w_next_state  = ST_FINISH;
          w_timeout_now = 1'b1;
        end
      end
      ST_RD_GAP: begin
        if (w_gap_end) begin
          if (w_last) begin
`ifdef CFG_REPORT_EN
            w_next_state = ST_REPORT;
`else
            w_next_state = ST_FINISH;
`endif
          end else begin
            w_next_state = ST_RD_REQ;
            w_lfsr_step  = 1'b1;
          end
        end
      end
      ST_RPT_GAP: if (w_gap_end) w_next_state = ST_FINISH;
      ST_FINISH:  w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= ST_IDLE;
    else                r_state <= w_next_state;
  end

  // Per-state timers and channel-done flags, rearmed on every state change.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_tmo     <= '0;
      r_gap     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else if (w_next_state != r_state) begin
      r_tmo     <= TMO_LOAD;
      r_gap     <= GAP_LOAD;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else begin
      if (!w_tmo_hit) r_tmo <= r_tmo - TMO_W'(1);
      if (!w_gap_end) r_gap <= r_gap - GAP_W'(1);
      if (w_aw_hs)    r_aw_done <= 1'b1;
      if (w_w_hs)     r_w_done  <= 1'b1;
      if (w_ar_hs)    r_ar_done <= 1'b1;
    end
  end

  // Word address/index, error tracking and pass/timeout status.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_err       <= '0;
      r_fail_addr <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_addr      <= BASE_ADDR;
        r_cnt       <= '0;
        r_err       <= '0;
        r_fail_addr <= '0;
        r_timeout   <= 1'b0;
        r_pass      <= 1'b0;
      end
      if ((r_state == ST_WR_GAP || r_state == ST_RD_GAP) && w_gap_end) begin
        if (w_last) begin
          r_addr <= BASE_ADDR;
          r_cnt  <= '0;
        end else begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
          r_cnt  <= r_cnt + CNT_W'(1);
        end
      end
      if (w_rd_complete && w_mismatch) begin
        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (r_err == 16'd0)    r_fail_addr <= r_addr;
      end
      if (w_timeout_now)         r_timeout <= 1'b1;
      if (r_state == ST_FINISH)  r_pass    <= w_pass_now;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);
  assign pass      = done ? w_pass_now : r_pass;
  assign err_count = r_err;
  assign fail_addr = r_fail_addr;
  assign timeout   = r_timeout;

  assign m_axi.M_AXI_AWVALID = w_awvalid;
  assign m_axi.M_AXI_WVALID  = w_wvalid;
  assign m_axi.M_AXI_ARVALID = w_arvalid;
  assign m_axi.M_AXI_RREADY  = w_rready;
  assign m_axi.M_AXI_AWADDR  = (r_state == ST_WR_REQ) ? r_addr :
                               (r_state == ST_REPORT) ? REPORT_ADDR : '0;
  assign m_axi.M_AXI_WDATA   = (r_state == ST_WR_REQ) ? DATA_WIDTH'(w_lfsr) :
                               (r_state == ST_REPORT) ? DATA_WIDTH'({16'h0, r_err}) : '0;
  assign m_axi.M_AXI_ARADDR  = (r_state == ST_RD_REQ) ? r_addr : '0;
endmodule
